mc_datapath_gen: RTL and testbench

MC_DATAPATH_GEN -- requirements
Module: mc_datapath_gen

---
 rtl/mc_datapath_gen.sv | 204 ++++++++++++++++++++
 tb/tb_mc_datapath_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_gen.sv
// Multicycle processor datapath with a shift-add multiplier.
// The multiplier is built only when MC_DATAPATH_MUL_EN is defined.
module mc_datapath_gen #(
  parameter int WIDTH = 32,
  parameter int NREG  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] Adr,
  output logic [WIDTH-1:0] WriteData,
  output logic [31:0]      Instr,
  output logic [3:0]       ALUFlags,
  input  logic             PCWrite,
  input  logic             RegWrite,
  input  logic             IRWrite,
  input  logic             AdrSrc,
  input  logic             ALUSrcA,
  input  logic [1:0]       RegSrc,
  input  logic [1:0]       ALUSrcB,
  input  logic [1:0]       ResultSrc,
  input  logic [1:0]       ImmSrc,
  input  logic [1:0]       ALUControl,
  input  logic             MulStart,
  output logic             MulBusy,
  output logic             MulDone
);
  localparam int RAW = $clog2(NREG);
  localparam logic [RAW-1:0] PC_ADR = RAW'(NREG - 1);

  logic [WIDTH-1:0] pc_reg, data_reg, a_reg, b_reg, aluout_reg;
  logic [31:0]      instr_reg;
  logic [WIDTH-1:0] rf [NREG];
  logic [RAW-1:0]   ra1, ra2, wa;
  logic [WIDTH-1:0] rd1, rd2, ext_imm, src_a, src_b, alu_result, result, mul_result;
  logic [WIDTH:0]   sum;
  logic             flag_c, flag_v;

  assign ra1 = RegSrc[0] ? PC_ADR : instr_reg[16 +: RAW];
  assign ra2 = RegSrc[1] ? instr_reg[12 +: RAW] : instr_reg[0 +: RAW];
  assign wa  = instr_reg[12 +: RAW];

  // The top register address aliases the current Result rather than storage.
  assign rd1 = (ra1 == PC_ADR) ? result : rf[ra1];
  assign rd2 = (ra2 == PC_ADR) ? result : rf[ra2];

  always_ff @(posedge clk) begin
    if (RegWrite && (wa != PC_ADR))
      rf[wa] <= result;
  end

  always_comb begin
    case (ImmSrc)
      2'd0:    ext_imm = {{(WIDTH-8){1'b0}}, instr_reg[7:0]};
      2'd1:    ext_imm = {{(WIDTH-12){1'b0}}, instr_reg[11:0]};
      2'd2:    ext_imm = {{(WIDTH-26){instr_reg[23]}}, instr_reg[23:0], 2'b00};
      default: ext_imm = '0;
    endcase
  end

  assign src_a = ALUSrcA ? a_reg : pc_reg;

  always_comb begin
    case (ALUSrcB)
      2'd0:    src_b = b_reg;
      2'd1:    src_b = ext_imm;
      2'd2:    src_b = WIDTH'(4);
      default: src_b = '0;
    endcase
  end

  // Subtraction is a + ~b + 1 so the carry out reads as "no borrow".
  always_comb begin
    sum        = '0;
    alu_result = '0;
    flag_c     = 1'b0;
    flag_v     = 1'b0;
    case (ALUControl)
      2'd0: begin
        sum        = {1'b0, src_a} + {1'b0, src_b};
        alu_result = sum[WIDTH-1:0];
        flag_c     = sum[WIDTH];
        flag_v     = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_result[WIDTH-1] != src_a[WIDTH-1]);
      end
      2'd1: begin
        sum        = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_result = sum[WIDTH-1:0];
        flag_c     = sum[WIDTH];
        flag_v     = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_result[WIDTH-1] != src_a[WIDTH-1]);
      end
      2'd2:    alu_result = src_a & src_b;
      default: alu_result = src_a | src_b;
    endcase
  end

  assign ALUFlags = {alu_result[WIDTH-1], (alu_result == '0), flag_c, flag_v};

  always_comb begin
    case (ResultSrc)
      2'd0:    result = aluout_reg;
      2'd1:    result = data_reg;
      2'd2:    result = alu_result;
      default: result = mul_result;
    endcase
  end

  assign Adr       = AdrSrc ? result : pc_reg;
  assign WriteData = b_reg;
  assign Instr     = instr_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg     <= '0;
      instr_reg  <= '0;
      data_reg   <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      aluout_reg <= '0;
    end else begin
      if (PCWrite) pc_reg <= result;
      if (IRWrite) instr_reg <= ReadData[31:0];
      data_reg   <= ReadData;
      a_reg      <= rd1;
      b_reg      <= rd2;
      aluout_reg <= alu_result;
    end
  end

`ifdef MC_DATAPATH_MUL_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
  localparam int CW = $clog2(WIDTH);

  mul_state_t       state_reg, state_next;
  logic [WIDTH-1:0] mcand_reg, mcand_next, mplier_reg, mplier_next;
  logic [WIDTH-1:0] acc_reg, acc_next, prod_reg, prod_next;
  logic [CW-1:0]    cnt_reg, cnt_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      prod_reg   <= '0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      prod_reg   <= prod_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    prod_next   = prod_reg;
    cnt_next    = cnt_reg;
    MulBusy     = 1'b0;
    MulDone     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (MulStart) begin
          state_next  = RUN;
          mcand_next  = a_reg;
          mplier_next = b_reg;
          acc_next    = '0;
          cnt_next    = '0;
        end
      end
      RUN: begin
        MulBusy     = 1'b1;
        acc_next    = acc_reg + (mplier_reg[0] ? mcand_reg : {WIDTH{1'b0}});
        mcand_next  = mcand_reg << 1;
        mplier_next = mplier_reg >> 1;
        cnt_next    = cnt_reg + 1'b1;
        // Product is captured on the last iteration so it is visible during DONE.
        if (cnt_reg == CW'(WIDTH - 1)) begin
          state_next = DONE;
          prod_next  = acc_next;
        end
      end
      DONE: begin
        MulDone    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mul_result = prod_reg;
`else
  logic unused_mulstart;
  assign unused_mulstart = MulStart;
  assign MulBusy    = 1'b0;
  assign MulDone    = 1'b0;
  assign mul_result = '0;
`endif

endmodule

// File: tb/tb_mc_datapath_gen.sv
// Scoreboard bench for mc_datapath_gen: the driver queues expected observations,
// the negedge monitor pops and compares them, and multiplier results are checked on MulDone.
`timescale 1ns/1ps
module tb_mc_datapath_gen;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  ReadData, Adr, WriteData;
  logic [31:0]   Instr;
  logic [3:0]    ALUFlags;
  logic          PCWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
  logic [1:0]    RegSrc, ALUSrcB, ResultSrc, ImmSrc, ALUControl;
  logic          MulStart, MulBusy, MulDone;

  mc_datapath_gen #(.WIDTH(W), .NREG(16)) dut (
    .clk(clk), .reset(reset), .ReadData(ReadData), .Adr(Adr), .WriteData(WriteData),
    .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .RegSrc(RegSrc),
    .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // sel: 0 Adr, 1 ALUFlags, 2 WriteData, 3 Instr, 4 MulBusy, 5 MulDone
  typedef struct { int cyc; int sel; logic [W-1:0] val; string name; } exp_t;
  typedef struct { int cyc; logic [W-1:0] prod; } mul_t;
  exp_t exp_q[$];
  mul_t mul_q[$];

  int checks = 0, errors = 0, done_seen = 0, busy_cnt = 0;
  logic [W-1:0] m_rf [15];
  logic [W-1:0] m_pc;

  task automatic expect_v(int sel, logic [W-1:0] val, string name);
    exp_q.push_back('{cyc, sel, val, name});
  endtask

  always @(negedge clk) begin
    exp_t it;
    mul_t m;
    logic [W-1:0] act;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      it = exp_q.pop_front();
      case (it.sel)
        0:       act = Adr;
        1:       act = {28'h0, ALUFlags};
        2:       act = WriteData;
        3:       act = Instr;
        4:       act = {31'h0, MulBusy};
        default: act = {31'h0, MulDone};
      endcase
      checks++;
      if (act !== it.val) begin
        errors++;
        $display("FAIL %s cyc %0d actual %h required %h", it.name, cyc, act, it.val);
      end else
        $display("ok   %s cyc %0d value %h", it.name, cyc, act);
    end
    if (!reset) busy_cnt = 0;
    else if (MulBusy) busy_cnt++;
    if (MulDone) begin
      done_seen++;
      checks++;
      if (mul_q.size() == 0) begin
        errors++;
        $display("FAIL mul_unexpected_done cyc %0d actual 1 required 0", cyc);
      end else begin
        m = mul_q.pop_front();
        if ((cyc - m.cyc) != W + 1) begin
          errors++;
          $display("FAIL mul_latency actual %0d required %0d", cyc - m.cyc, W + 1);
        end
        checks++;
        if (busy_cnt != W) begin
          errors++;
          $display("FAIL mul_busy_cycles actual %0d required %0d", busy_cnt, W);
        end
        checks++;
        if (Adr !== m.prod) begin
          errors++;
          $display("FAIL mul_product actual %h required %h", Adr, m.prod);
        end else
          $display("ok   mul_product cyc %0d value %h busy %0d", cyc, Adr, busy_cnt);
      end
      busy_cnt = 0;
    end
  end

  function automatic logic [35:0] alu_ref(logic [W-1:0] a, logic [W-1:0] b, logic [1:0] ctl);
    longint ua, ub, sa, sb, s;
    logic [W-1:0] r;
    logic c, v;
    ua = {32'h0, a}; ub = {32'h0, b};
    sa = $signed(a); sb = $signed(b);
    c = 1'b0; v = 1'b0; s = 0;
    case (ctl)
      2'd0: begin r = a + b; c = ((ua + ub) >> 32) != 0; s = sa + sb; end
      2'd1: begin r = a - b; c = (ua >= ub); s = sa - sb; end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    if (ctl <= 2'd1) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {r[W-1], (r == 0), c, v, r};
  endfunction

  function automatic logic [W-1:0] imm_ref(logic [31:0] ins, logic [1:0] is);
    case (is)
      2'd0:    return W'(ins[7:0]);
      2'd1:    return W'(ins[11:0]);
      2'd2:    return W'(longint'($signed(ins[23:0])) * 4);
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] rd_ref(int a, logic [W-1:0] alias_v);
    if (a == 15) return alias_v;
    return m_rf[a];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 0; ALUSrcA = 0;
    RegSrc = 0; ALUSrcB = 0; ResultSrc = 0; ImmSrc = 0; ALUControl = 0;
    MulStart = 0; ReadData = '0;
  endtask

  task automatic write_reg(int r, logic [W-1:0] val);
    clr(); ReadData = W'(r) << 12; IRWrite = 1; step();
    clr(); ReadData = val; step();
    clr(); RegWrite = 1; ResultSrc = 2'd1; AdrSrc = 1;
    expect_v(0, val, "wr_result"); step();
    if (r != 15) m_rf[r] = val;
  endtask

  // IR load, then A/B capture (Result = PC+4 feeds any alias read), then the ALU op.
  task automatic do_op(logic [31:0] ins, logic [1:0] rs, logic sa, logic [1:0] sb,
                       logic [1:0] is, logic [1:0] ctl, string nm);
    logic [W-1:0] av, bv, opa, opb;
    logic [35:0] r;
    int n1, n2;
    clr(); ReadData = ins; IRWrite = 1; step();
    n1 = rs[0] ? 15 : int'(ins[19:16]);
    n2 = rs[1] ? int'(ins[15:12]) : int'(ins[3:0]);
    av = rd_ref(n1, m_pc + 4);
    bv = rd_ref(n2, m_pc + 4);
    clr(); RegSrc = rs; ALUSrcB = 2'd2; ResultSrc = 2'd2; step();
    opa = sa ? av : m_pc;
    case (sb)
      2'd0:    opb = bv;
      2'd1:    opb = imm_ref(ins, is);
      2'd2:    opb = 4;
      default: opb = 0;
    endcase
    r = alu_ref(opa, opb, ctl);
    clr(); ALUSrcA = sa; ALUSrcB = sb; ImmSrc = is; ALUControl = ctl; ResultSrc = 2'd2; AdrSrc = 1;
    expect_v(0, r[31:0], {nm, "_res"});
    expect_v(1, {28'h0, r[35:32]}, {nm, "_flags"});
    expect_v(2, bv, {nm, "_wd"});
    expect_v(3, ins, {nm, "_instr"});
    step();
    clr(); AdrSrc = 1; ResultSrc = 2'd0;
    expect_v(0, r[31:0], {nm, "_aluout"});
    step();
  endtask

`ifdef MC_DATAPATH_MUL_EN
  task automatic mul_start(logic [W-1:0] x, logic [W-1:0] y, string nm);
    write_reg(1, x); write_reg(2, y);
    clr(); ReadData = 32'h0001_0002; IRWrite = 1; step();
    clr(); step();
    clr(); MulStart = 1; AdrSrc = 1; ResultSrc = 2'd3;
    expect_v(4, 0, {nm, "_idle_busy"});
    mul_q.push_back('{cyc, x * y});
    step();
  endtask

  task automatic mul_test(logic [W-1:0] x, logic [W-1:0] y, string nm);
    int base;
    base = done_seen;
    mul_start(x, y, nm);
    for (int i = 0; i < 200 && done_seen == base; i++) begin
      clr(); AdrSrc = 1; ResultSrc = 2'd3; MulStart = (i == 5);
      step();
    end
    if (done_seen == base) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual no MulDone required MulDone", nm);
    end
  endtask
`endif

  initial begin
    #1ms;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr(); reset = 0;
    step();
    ReadData = 32'hDEADBEEF; IRWrite = 1;
    expect_v(0, 0, "rst_pc"); expect_v(3, 0, "rst_instr"); expect_v(2, 0, "rst_wd");
    expect_v(4, 0, "rst_busy"); expect_v(5, 0, "rst_done");
    step();
    AdrSrc = 1; ResultSrc = 2'd1;
    expect_v(0, 0, "rst_data"); expect_v(3, 0, "rst_instr_hold");
    step();
    clr(); reset = 1;

    for (int k = 0; k < 3; k++) begin
      clr(); PCWrite = 1; ALUSrcB = 2'd2; ResultSrc = 2'd2;
      expect_v(0, W'(4 * k), "pc_inc");
      step();
    end
    clr(); expect_v(0, 32'hC, "pc_final"); step();
    m_pc = 32'hC;

    for (int r = 0; r < 15; r++) write_reg(r, $urandom);

    write_reg(1, 32'h7FFF_FFFF); write_reg(2, 32'h1);
    do_op(32'h0001_0002, 2'd0, 1'b1, 2'd0, 2'd0, 2'd0, "add_ovf");
    do_op(32'h0001_0001, 2'd0, 1'b1, 2'd0, 2'd0, 2'd1, "sub_zero");

    write_reg(15, 32'h1234);
    do_op(32'h000F_000F, 2'd0, 1'b1, 2'd0, 2'd0, 2'd3, "r15_alias");
    do_op(32'h0001_0002, 2'd0, 1'b1, 2'd0, 2'd0, 2'd3, "r1r2_kept");
    do_op(32'h00FF_FFFE, 2'd0, 1'b0, 2'd1, 2'd2, 2'd0, "imm_neg");

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) write_reg(int'($urandom_range(0, 15)), $urandom);
      do_op($urandom, 2'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), "rand");
    end

`ifdef MC_DATAPATH_MUL_EN
    mul_test(32'h0000_FFFF, 32'h0001_0001, "mul_dir");
    clr(); AdrSrc = 1; ResultSrc = 2'd3; expect_v(0, 32'hFFFF_FFFF, "mul_hold"); step();
    mul_test($urandom, $urandom, "mul_rand");
    mul_test($urandom, $urandom, "mul_rand");
    mul_start($urandom | 32'h1, $urandom | 32'h1, "mul_abort");
    for (int i = 0; i < 9; i++) begin clr(); AdrSrc = 1; ResultSrc = 2'd3; step(); end
    reset = 0;
    mul_q.delete();
    expect_v(4, 0, "abort_busy"); expect_v(5, 0, "abort_done"); expect_v(0, 0, "abort_mulres");
    step();
    expect_v(0, 0, "abort_mulres_hold");
    step();
    reset = 1; m_pc = 0;
    for (int i = 0; i < W + 8; i++) begin
      clr(); AdrSrc = 1; ResultSrc = 2'd3;
      if (i == W) expect_v(0, 0, "abort_no_result");
      step();
    end
`else
    clr(); MulStart = 1; AdrSrc = 1; ResultSrc = 2'd3; expect_v(0, 0, "nomul_res"); step();
    for (int i = 0; i < W + 4; i++) begin
      clr(); AdrSrc = 1; ResultSrc = 2'd3;
      if (i == 0 || i == W) begin
        expect_v(4, 0, "nomul_busy"); expect_v(0, 0, "nomul_res_hold");
      end
      step();
    end
`endif

    clr(); repeat (3) step();
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL pending_expectations actual %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
